div_ctrl: RTL and testbench

DIV_CTRL -- requirements
Module: div_ctrl

---
 rtl/div_ctrl.sv | 142 ++++++++++++++
 tb/tb_div_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_ctrl.sv
// div_ctrl -- iterative 32-bit divider controller for the EX stage.
//
// Performs signed (DIV) or unsigned (DIVU) division with a restoring
// algorithm, one quotient bit per clock over 32 RUN cycles. Division by zero
// skips the iteration and returns zero for both results. The result
// registers are written only on entry to DONE. Between DONE entries they
// hold their values.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   start      divide request (held high while EX stalls)
//   annul      cancel any divide in progress (priority over start)
//   signed_op  1 = signed divide, 0 = unsigned
//   dividend   numerator, sampled when the request is accepted
//   divisor    denominator, sampled when the request is accepted
//   stall_req  combinational stall request to the pipeline controller
//   ready      one-cycle pulse while the result is valid (state DONE)
//   quotient   registered quotient (LO)
//   remainder  registered remainder (HI)
module div_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        annul,
    input  logic        signed_op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        stall_req,
    output logic        ready,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    typedef enum logic [1:0] {IDLE, BYZERO, RUN, DONE} state_t;

    state_t      state_reg;
    logic [4:0]  count_reg;
    logic [31:0] work_q_reg;    // dividend bits shift out as quotient bits shift in
    logic [31:0] work_r_reg;    // partial remainder
    logic [31:0] dsr_reg;       // divisor magnitude
    logic        op_signed_reg;
    logic        sign_a_reg;
    logic        sign_b_reg;

    // Operand magnitudes for acceptance in IDLE
    logic [31:0] abs_a;
    logic [31:0] abs_b;

    // One restoring step
    logic [32:0] shifted;
    logic        ge;
    logic [31:0] diff;
    logic [31:0] r_step;
    logic [31:0] q_step;
    logic [31:0] q_fixed;
    logic [31:0] r_fixed;

    always_comb begin
        abs_a = (signed_op && dividend[31]) ? (~dividend + 32'd1) : dividend;
        abs_b = (signed_op && divisor[31])  ? (~divisor + 32'd1)  : divisor;

        shifted = {work_r_reg, work_q_reg[31]};
        ge      = (shifted >= {1'b0, dsr_reg});
        // When ge holds, the difference is below the divisor and fits 32 bits.
        diff    = shifted[31:0] - dsr_reg;
        r_step  = ge ? diff : shifted[31:0];
        q_step  = {work_q_reg[30:0], ge};

        // Sign correction: quotient negated when signs differ, remainder
        // follows the dividend's sign. 0x80000000 / -1 wraps back to
        // 0x80000000, which is the required result.
        q_fixed = (op_signed_reg && (sign_a_reg ^ sign_b_reg)) ? (~q_step + 32'd1) : q_step;
        r_fixed = (op_signed_reg && sign_a_reg) ? (~r_step + 32'd1) : r_step;
    end

    assign stall_req = start & ~annul & ~ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            count_reg     <= 5'd0;
            ready         <= 1'b0;
            quotient      <= 32'd0;
            remainder     <= 32'd0;
            work_q_reg    <= 32'd0;
            work_r_reg    <= 32'd0;
            dsr_reg       <= 32'd0;
            op_signed_reg <= 1'b0;
            sign_a_reg    <= 1'b0;
            sign_b_reg    <= 1'b0;
        end else begin
            ready <= 1'b0;
            if (annul) begin
                state_reg <= IDLE;
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (start) begin
                            if (divisor == 32'd0) begin
                                state_reg <= BYZERO;
                            end else begin
                                state_reg     <= RUN;
                                work_q_reg    <= abs_a;
                                work_r_reg    <= 32'd0;
                                dsr_reg       <= abs_b;
                                op_signed_reg <= signed_op;
                                sign_a_reg    <= dividend[31];
                                sign_b_reg    <= divisor[31];
                                count_reg     <= 5'd0;
                            end
                        end
                    end
                    BYZERO: begin
                        quotient  <= 32'd0;
                        remainder <= 32'd0;
                        ready     <= 1'b1;
                        state_reg <= DONE;
                    end
                    RUN: begin
                        work_q_reg <= q_step;
                        work_r_reg <= r_step;
                        count_reg  <= count_reg + 5'd1;
                        if (count_reg == 5'd31) begin
                            quotient  <= q_fixed;
                            remainder <= r_fixed;
                            ready     <= 1'b1;
                            state_reg <= DONE;
                        end
                    end
                    DONE: begin
                        state_reg <= IDLE;
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl -- self-checking bench for div_ctrl.
//
// A cycle-level reference model tracks when a result is due and what it
// must be (computed with plain integer division). A compare process checks
// ready, stall_req, quotient and remainder against it on every falling
// edge. Directed scenarios add literal expectations for values and latency.
module tb_div_ctrl;

    logic        clk;
    logic        reset;
    logic        start;
    logic        annul;
    logic        signed_op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        stall_req;
    logic        ready;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int checks = 0;
    int errors = 0;

    div_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .annul     (annul),
        .signed_op (signed_op),
        .dividend  (dividend),
        .divisor   (divisor),
        .stall_req (stall_req),
        .ready     (ready),
        .quotient  (quotient),
        .remainder (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference arithmetic ----------------
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    input logic s, output logic [31:0] q,
                                    output logic [31:0] r);
        int sa;
        int sb;
        if (b == 32'd0) begin
            q = 32'd0;
            r = 32'd0;
        end else if (!s) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            sa = a;
            sb = b;
            q = sa / sb;
            r = sa % sb;
        end
    endfunction

    // ---------------- cycle-level model ----------------
    int          cyc = 0;        // index of the current clock cycle
    bit          busy = 0;
    int          done_cycle = 0;
    logic [31:0] pend_q = 0, pend_r = 0;
    logic [31:0] held_q = 0, held_r = 0;

    always @(negedge reset) begin
        busy   = 0;
        held_q = 0;
        held_r = 0;
    end

    always @(posedge clk) begin
        if (reset) begin
            if (busy && cyc == done_cycle) begin
                busy   = 0;
                held_q = pend_q;
                held_r = pend_r;
            end else if (annul) begin
                busy = 0;
            end else if (!busy && start) begin
                busy       = 1;
                done_cycle = cyc + ((divisor == 32'd0) ? 2 : 33);
                ref_div(dividend, divisor, signed_op, pend_q, pend_r);
            end
        end
        cyc = cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Per-cycle compare against the model
    always @(negedge clk) begin
        logic        exp_ready;
        logic [31:0] exp_q, exp_r;
        if (!reset) begin
            exp_ready = 1'b0;
            exp_q     = 32'd0;
            exp_r     = 32'd0;
        end else begin
            exp_ready = busy && (cyc == done_cycle);
            exp_q     = exp_ready ? pend_q : held_q;
            exp_r     = exp_ready ? pend_r : held_r;
        end
        check("ready", {31'd0, ready}, {31'd0, exp_ready});
        check("stall_req", {31'd0, stall_req}, {31'd0, start & ~annul & ~exp_ready});
        check("quotient", quotient, exp_q);
        check("remainder", remainder, exp_r);
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_ready(output int c);
        c = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ready) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got no ready expected ready within 40 cycles (cycle %0d)", cyc);
        end
    endtask

    task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic s, input logic [31:0] eq, input logic [31:0] er,
                           input int lat);
        int t0;
        int tr;
        @(posedge clk);
        #1;
        start     = 1'b1;
        signed_op = s;
        dividend  = a;
        divisor   = b;
        t0        = cyc;
        wait_ready(tr);
        check({name, "_lat"}, tr - t0, lat);
        check({name, "_q"}, quotient, eq);
        check({name, "_r"}, remainder, er);
        $display("div %s: %h / %h signed=%0d -> q=%h r=%h latency=%0d",
                 name, a, b, s, quotient, remainder, tr - t0);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        int c1, c2, c3;
        logic [31:0] mq, mr;
        reset     = 1'b0;
        start     = 1'b0;
        annul     = 1'b0;
        signed_op = 1'b0;
        dividend  = 32'd0;
        divisor   = 32'd0;

        // Pin the reference arithmetic with hand-computed values
        ref_div(32'd100, 32'd7, 1'b0, mq, mr);
        check("model_100_7", {mq[15:0], mr[15:0]}, {16'd14, 16'd2});
        ref_div(32'hFFFF_FFF9, 32'd2, 1'b1, mq, mr);
        check("model_m7_2_q", mq, 32'hFFFF_FFFD);
        check("model_m7_2_r", mr, 32'hFFFF_FFFF);

        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", {31'd0, ready}, 32'd0);
        check("reset_q", quotient, 32'd0);
        check("reset_r", remainder, 32'd0);
        reset = 1'b1;

        run_div("u100_7",   32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          33);
        run_div("s_m7_2",   32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF,  33);
        run_div("s_7_m2",   32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1,          33);
        run_div("s_m7_m2",  32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b1, 32'd3,          32'hFFFF_FFFF,  33);
        run_div("u_big_1",  32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          33);
        run_div("u_5_9",    32'd5,          32'd9,          1'b0, 32'd0,          32'd5,          33);
        run_div("byzero",   32'h1234,       32'd0,          1'b0, 32'd0,          32'd0,          2);
        run_div("u_1000_3", 32'd1000,       32'd3,          1'b0, 32'd333,        32'd1,          33);

        // Annul in the 10th RUN cycle: no ready, results keep 333/1
        @(posedge clk);
        #1;
        start     = 1'b1;
        signed_op = 1'b0;
        dividend  = 32'd99;
        divisor   = 32'd4;
        repeat (10) @(posedge clk);
        #1;
        annul = 1'b1;
        @(negedge clk);
        check("annul_stall", {31'd0, stall_req}, 32'd0);
        @(posedge clk);
        #1;
        annul = 1'b0;
        start = 1'b0;
        repeat (40) @(negedge clk);
        check("annul_hold_q", quotient, 32'd333);
        check("annul_hold_r", remainder, 32'd1);
        $display("annul: results held q=%h r=%h", quotient, remainder);

        // Reset in the 20th RUN cycle, then restart
        @(posedge clk);
        #1;
        start     = 1'b1;
        signed_op = 1'b0;
        dividend  = 32'd50;
        divisor   = 32'd6;
        repeat (20) @(posedge clk);
        #1;
        reset = 1'b0;
        start = 1'b0;
        #1;
        check("midreset_ready", {31'd0, ready}, 32'd0);
        check("midreset_q", quotient, 32'd0);
        check("midreset_r", remainder, 32'd0);
        $display("mid-run reset: q=%h r=%h ready=%0d", quotient, remainder, ready);
        @(posedge clk);
        #1;
        reset = 1'b1;
        run_div("restart",  32'd50,         32'd6,          1'b0, 32'd8,          32'd2,          33);

        // Back-to-back with start held high
        @(posedge clk);
        #1;
        start     = 1'b1;
        signed_op = 1'b1;
        dividend  = 32'h8000_0000;
        divisor   = 32'hFFFF_FFFF;
        wait_ready(c1);
        check("b2b1_q", quotient, 32'h8000_0000);
        check("b2b1_r", remainder, 32'd0);
        signed_op = 1'b0;
        dividend  = 32'hFFFF_FFFF;
        divisor   = 32'h10;
        wait_ready(c2);
        check("b2b2_q", quotient, 32'h0FFF_FFFF);
        check("b2b2_r", remainder, 32'hF);
        check("b2b_gap1", c2 - c1, 34);
        dividend  = 32'h0FFF_FFFF;
        divisor   = 32'hF;
        wait_ready(c3);
        check("b2b3_q", quotient, 32'h0111_1111);
        check("b2b3_r", remainder, 32'd0);
        check("b2b_gap2", c3 - c2, 34);
        $display("back-to-back: ready at cycles %0d %0d %0d", c1, c2, c3);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
